decode_stage: RTL and testbench

Registered, parametrised RISC-V instruction decode stage between fetch and execute. Decodes one 32-bit instruction per cycle into register indices, fields, a one-hot format vector and an XLEN-wide sign-extended immediate. Supports RV32I and RV64I, including the RV64 word-op opcodes, and flags illegal encodings. Fetch and execute connect through valid/ready handshakes, and a 2-entry skid buffer provides full throughput under back-pressure. A flush input drops everything in flight.

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/imm_gen.sv | 31 +++
 rtl/decode_stage.sv | 146 ++++++++++++++
 tb/tb_decode_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Opcode constants, format bit positions and the decoded-field record for the decode stage.
package riscv_pkg;

  localparam logic [6:0] R_TYPE   = 7'b0110011;
  localparam logic [6:0] R_TYPE_W = 7'b0111011;
  localparam logic [6:0] I_TYPE_0 = 7'b0010011;
  localparam logic [6:0] I_TYPE_1 = 7'b0000011;
  localparam logic [6:0] I_TYPE_2 = 7'b1100111;
  localparam logic [6:0] I_TYPE_3 = 7'b1110011;
  localparam logic [6:0] I_TYPE_W = 7'b0011011;
  localparam logic [6:0] S_TYPE   = 7'b0100011;
  localparam logic [6:0] B_TYPE   = 7'b1100011;
  localparam logic [6:0] U_TYPE_0 = 7'b0110111;
  localparam logic [6:0] U_TYPE_1 = 7'b0010111;
  localparam logic [6:0] J_TYPE   = 7'b1101111;

  // Bit positions inside the one-hot format vector {j,u,b,s,i,r}
  localparam int FMT_R = 0;
  localparam int FMT_I = 1;
  localparam int FMT_S = 2;
  localparam int FMT_B = 3;
  localparam int FMT_U = 4;
  localparam int FMT_J = 5;

  // XLEN-independent part of the decoded bundle; the stage wraps it with pc and imm.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [5:0] fmt;
    logic       word_op;
    logic       illegal;
  } decode_fields_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: picks the format's bit layout and sign-extends to XLEN.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  logic [5:1]      fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] raw;

  always_comb begin
    raw = '0;
    if (fmt[FMT_I])
      raw = {{20{instr[31]}}, instr[31:20]};
    else if (fmt[FMT_S])
      raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    else if (fmt[FMT_B])
      raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    else if (fmt[FMT_U])
      raw = {instr[31:12], 12'h000};
    else if (fmt[FMT_J])
      raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  end

  // Every layout is already sign-extended to 32 bits; widen from bit 31 for RV64.
  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with valid/ready handshakes, a skid entry and flush.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [PC_W-1:0] pc_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [6:0]      op_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [5:0]      type_o,
  output logic            word_op_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] imm_o
);

  localparam int IMM_W = XLEN;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    decode_fields_t   f;
    logic [IMM_W-1:0] imm;
  } decode_bundle_t;

  logic [5:0]       fmt;
  logic             word_op;
  logic [IMM_W-1:0] imm_dec;
  decode_bundle_t   dec;

  always_comb begin
    fmt     = '0;
    word_op = 1'b0;
    if (instr_i[1:0] == 2'b11) begin
      case (instr_i[6:0])
        R_TYPE: fmt[FMT_R] = 1'b1;
        R_TYPE_W:
          if (XLEN == 64) begin
            fmt[FMT_R] = 1'b1;
            word_op    = 1'b1;
          end
        I_TYPE_0, I_TYPE_1, I_TYPE_2, I_TYPE_3: fmt[FMT_I] = 1'b1;
        I_TYPE_W:
          if (XLEN == 64) begin
            fmt[FMT_I] = 1'b1;
            word_op    = 1'b1;
          end
        S_TYPE:             fmt[FMT_S] = 1'b1;
        B_TYPE:             fmt[FMT_B] = 1'b1;
        U_TYPE_0, U_TYPE_1: fmt[FMT_U] = 1'b1;
        J_TYPE:             fmt[FMT_J] = 1'b1;
        default:            fmt = '0;
      endcase
    end
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr_i[31:7]),
    .fmt   (fmt[5:1]),
    .imm   (imm_dec)
  );

  always_comb begin
    dec           = '0;
    dec.pc        = pc_i;
    dec.f.rs1     = instr_i[19:15];
    dec.f.rs2     = instr_i[24:20];
    dec.f.rd      = instr_i[11:7];
    dec.f.op      = instr_i[6:0];
    dec.f.funct3  = instr_i[14:12];
    dec.f.funct7  = instr_i[31:25];
    dec.f.fmt     = fmt;
    dec.f.word_op = word_op;
    dec.f.illegal = (fmt == '0);
    dec.imm       = imm_dec;
  end

  decode_bundle_t out_q;
  decode_bundle_t skid_q;
  logic           valid_q;
  logic           skid_valid_q;
  logic           in_ready_q;

  logic accept;
  logic out_load;

  assign accept   = valid_i && in_ready_q;
  assign out_load = !valid_q || ready_i;

  // accept is never true while the skid is full, so the skid path cannot collide with a new input.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (flush_i) begin
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (out_load) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        valid_q      <= 1'b1;
        skid_valid_q <= 1'b0;
        in_ready_q   <= 1'b1;
      end else begin
        valid_q <= accept;
        if (accept)
          out_q <= dec;
      end
    end else if (accept) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
      in_ready_q   <= 1'b0;
    end
  end

  assign in_ready_o = in_ready_q;
  assign valid_o    = valid_q;
  assign pc_o       = out_q.pc;
  assign rs1_o      = out_q.f.rs1;
  assign rs2_o      = out_q.f.rs2;
  assign rd_o       = out_q.f.rd;
  assign op_o       = out_q.f.op;
  assign funct3_o   = out_q.f.funct3;
  assign funct7_o   = out_q.f.funct7;
  assign type_o     = out_q.f.fmt;
  assign word_op_o  = out_q.f.word_op;
  assign illegal_o  = out_q.f.illegal;
  assign imm_o      = out_q.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench: RV32 and RV64 instances share stimulus; vector table plus handshake sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, valid_in, ready;
  logic [31:0] instr;
  logic [63:0] pc64;
  logic [31:0] pc32;

  logic        in_ready32, valid32, wop32, ill32;
  logic [31:0] pco32, imm32;
  logic [4:0]  rs1_32, rs2_32, rd_32;
  logic [6:0]  op32, f7_32;
  logic [2:0]  f3_32;
  logic [5:0]  type32;

  logic        in_ready64, valid64, wop64, ill64;
  logic [63:0] pco64, imm64;
  logic [4:0]  rs1_64, rs2_64, rd_64;
  logic [6:0]  op64, f7_64;
  logic [2:0]  f3_64;
  logic [5:0]  type64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign pc32 = pc64[31:0];

  decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush_i(flush), .valid_i(valid_in), .in_ready_o(in_ready32),
    .instr_i(instr), .pc_i(pc32), .valid_o(valid32), .ready_i(ready), .pc_o(pco32),
    .rs1_o(rs1_32), .rs2_o(rs2_32), .rd_o(rd_32), .op_o(op32), .funct3_o(f3_32),
    .funct7_o(f7_32), .type_o(type32), .word_op_o(wop32), .illegal_o(ill32), .imm_o(imm32)
  );

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush_i(flush), .valid_i(valid_in), .in_ready_o(in_ready64),
    .instr_i(instr), .pc_i(pc64), .valid_o(valid64), .ready_i(ready), .pc_o(pco64),
    .rs1_o(rs1_64), .rs2_o(rs2_64), .rd_o(rd_64), .op_o(op64), .funct3_o(f3_64),
    .funct7_o(f7_64), .type_o(type64), .word_op_o(wop64), .illegal_o(ill64), .imm_o(imm64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  t32, t64;
    logic        i32, i64, w64;
    logic [31:0] imm32;
    logic [63:0] imm64;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    logic [31:0] ins;
    logic [15:0] got_pc[$];
    int          got_cyc[$];
    logic        acc;
    int          leak;

    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready = 1'b0;
    instr = 32'h0; pc64 = 64'h0;

    //           instr         rs1 rs2 rd  t32    t64    i32 i64 w64 imm32          imm64
    vecs.push_back('{32'hFFF10093, 2, 31, 1, 6'h02, 6'h02, 0, 0, 0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF});
    vecs.push_back('{32'h800000B7, 0, 0,  1, 6'h10, 6'h10, 0, 0, 0, 32'h80000000, 64'hFFFFFFFF80000000});
    vecs.push_back('{32'h123450B7, 8, 3,  1, 6'h10, 6'h10, 0, 0, 0, 32'h12345000, 64'h0000000012345000});
    vecs.push_back('{32'h0010809B, 1, 1,  1, 6'h00, 6'h02, 1, 0, 1, 32'h00000000, 64'h0000000000000001});
    vecs.push_back('{32'h00000000, 0, 0,  0, 6'h00, 6'h00, 1, 1, 0, 32'h00000000, 64'h0000000000000000});
    vecs.push_back('{32'hFE512E23, 2, 5, 28, 6'h04, 6'h04, 0, 0, 0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC});
    vecs.push_back('{32'h00208463, 1, 2,  8, 6'h08, 6'h08, 0, 0, 0, 32'h00000008, 64'h0000000000000008});
    vecs.push_back('{32'h000000E3, 0, 0,  1, 6'h08, 6'h08, 0, 0, 0, 32'h00000800, 64'h0000000000000800});
    vecs.push_back('{32'h80000063, 0, 0,  0, 6'h08, 6'h08, 0, 0, 0, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000});
    vecs.push_back('{32'h001000EF, 0, 1,  1, 6'h20, 6'h20, 0, 0, 0, 32'h00000800, 64'h0000000000000800});
    vecs.push_back('{32'h800000EF, 0, 0,  1, 6'h20, 6'h20, 0, 0, 0, 32'hFFF00000, 64'hFFFFFFFFFFF00000});
    vecs.push_back('{32'h000FF0EF, 31, 0, 1, 6'h20, 6'h20, 0, 0, 0, 32'h000FF000, 64'h00000000000FF000});
    vecs.push_back('{32'h402081B3, 1, 2,  3, 6'h01, 6'h01, 0, 0, 0, 32'h00000000, 64'h0000000000000000});
    vecs.push_back('{32'h002080BB, 1, 2,  1, 6'h00, 6'h01, 1, 0, 1, 32'h00000000, 64'h0000000000000000});
    vecs.push_back('{32'h00000012, 0, 0,  0, 6'h00, 6'h00, 1, 1, 0, 32'h00000000, 64'h0000000000000000});
    vecs.push_back('{32'hFFC08067, 1, 28, 0, 6'h02, 6'h02, 0, 0, 0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC});

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid32", 64'(valid32), 64'd0);
    chk("rst_valid64", 64'(valid64), 64'd0);
    chk("rst_ready32", 64'(in_ready32), 64'd1);
    chk("rst_ready64", 64'(in_ready64), 64'd1);
    chk("rst_pc64", pco64, 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_type64", 64'(type64), 64'd0);
    reset = 1'b0;

    // Decode table
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      ins = v.instr;
      @(negedge clk);
      instr = v.instr; pc64 = 64'h1000 + 64'(4 * i); valid_in = 1'b1; ready = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      chk($sformatf("v%0d_valid32", i), 64'(valid32), 64'd1);
      chk($sformatf("v%0d_valid64", i), 64'(valid64), 64'd1);
      chk($sformatf("v%0d_pc32", i), 64'(pco32), 64'h1000 + 64'(4 * i));
      chk($sformatf("v%0d_pc64", i), pco64, 64'h1000 + 64'(4 * i));
      chk($sformatf("v%0d_rs1", i), 64'(rs1_64), 64'(v.rs1));
      chk($sformatf("v%0d_rs2", i), 64'(rs2_64), 64'(v.rs2));
      chk($sformatf("v%0d_rd", i), 64'(rd_32), 64'(v.rd));
      chk($sformatf("v%0d_op", i), 64'(op64), 64'(ins[6:0]));
      chk($sformatf("v%0d_f3", i), 64'(f3_32), 64'(ins[14:12]));
      chk($sformatf("v%0d_f7", i), 64'(f7_64), 64'(ins[31:25]));
      chk($sformatf("v%0d_type32", i), 64'(type32), 64'(v.t32));
      chk($sformatf("v%0d_type64", i), 64'(type64), 64'(v.t64));
      chk($sformatf("v%0d_ill32", i), 64'(ill32), 64'(v.i32));
      chk($sformatf("v%0d_ill64", i), 64'(ill64), 64'(v.i64));
      chk($sformatf("v%0d_wop32", i), 64'(wop32), 64'd0);
      chk($sformatf("v%0d_wop64", i), 64'(wop64), 64'(v.w64));
      chk($sformatf("v%0d_imm32", i), 64'(imm32), 64'(v.imm32));
      chk($sformatf("v%0d_imm64", i), imm64, v.imm64);
    end

    // Back-pressure: A, B, C with ready low for three cycles
    @(negedge clk);
    instr = 32'hFFF10093; pc64 = 64'hA0; valid_in = 1'b1; ready = 1'b0;
    @(negedge clk);
    chk("bp_a_valid", 64'(valid64), 64'd1);
    chk("bp_a_pc", pco64, 64'hA0);
    chk("bp_ready_t1", 64'(in_ready64), 64'd1);
    pc64 = 64'hB0;
    @(negedge clk);
    chk("bp_ready_after_b", 64'(in_ready64), 64'd0);
    chk("bp_ready_after_b32", 64'(in_ready32), 64'd0);
    chk("bp_hold_pc", pco64, 64'hA0);
    chk("bp_hold_imm", imm64, 64'hFFFFFFFFFFFFFFFF);
    pc64 = 64'hC0;
    @(negedge clk);
    chk("bp_c_waits", 64'(in_ready64), 64'd0);
    chk("bp_hold_pc2", pco64, 64'hA0);
    ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      if (valid64 && ready) begin
        got_pc.push_back(pco64[15:0]);
        got_cyc.push_back(cyc);
      end
      acc = valid_in && in_ready64;
      @(negedge clk);
      if (acc && pc64 == 64'hC0) valid_in = 1'b0;
    end
    chk("bp_count", 64'(got_pc.size()), 64'd3);
    if (got_pc.size() == 3) begin
      chk("bp_order0", 64'(got_pc[0]), 64'hA0);
      chk("bp_order1", 64'(got_pc[1]), 64'hB0);
      chk("bp_order2", 64'(got_pc[2]), 64'hC0);
      chk("bp_consec1", 64'(got_cyc[1] - got_cyc[0]), 64'd1);
      chk("bp_consec2", 64'(got_cyc[2] - got_cyc[1]), 64'd1);
    end
    valid_in = 1'b0;

    // Flush with skid full and valid_i high, then flush racing an accept
    @(negedge clk);
    ready = 1'b0; valid_in = 1'b1; pc64 = 64'hD0;
    @(negedge clk);
    pc64 = 64'hE0;
    @(negedge clk);
    chk("fl_skid_full", 64'(in_ready64), 64'd0);
    pc64 = 64'hF0; flush = 1'b1;
    @(negedge clk);
    chk("fl_valid_clear", 64'(valid64), 64'd0);
    chk("fl_valid_clear32", 64'(valid32), 64'd0);
    chk("fl_ready_set", 64'(in_ready64), 64'd1);
    flush = 1'b0; pc64 = 64'h100; ready = 1'b1;
    @(negedge clk);
    chk("fl_next_valid", 64'(valid64), 64'd1);
    chk("fl_next_pc", pco64, 64'h100);
    pc64 = 64'h110; flush = 1'b1;
    @(negedge clk);
    chk("fl_same_cycle", 64'(valid64), 64'd0);
    flush = 1'b0; valid_in = 1'b0;
    leak = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      if (valid64 && (pco64 == 64'hD0 || pco64 == 64'hE0 || pco64 == 64'hF0 || pco64 == 64'h110))
        leak++;
      @(negedge clk);
    end
    chk("fl_no_leak", 64'(leak), 64'd0);

    // Reset mid-stream with both entries held
    ready = 1'b0; valid_in = 1'b1; instr = 32'hFFF10093; pc64 = 64'h200;
    @(negedge clk);
    pc64 = 64'h210;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_valid", 64'(valid64), 64'd0);
    chk("mr_ready", 64'(in_ready64), 64'd1);
    chk("mr_pc", pco64, 64'd0);
    chk("mr_imm", imm64, 64'd0);
    chk("mr_rd", 64'(rd_64), 64'd0);
    chk("mr_rs1", 64'(rs1_32), 64'd0);
    chk("mr_type", 64'(type32), 64'd0);
    chk("mr_ill", 64'(ill64), 64'd0);
    reset = 1'b0; instr = 32'h800000B7; pc64 = 64'h300; ready = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    chk("mr_after_valid", 64'(valid64), 64'd1);
    chk("mr_after_pc", pco64, 64'h300);
    chk("mr_after_imm64", imm64, 64'hFFFFFFFF80000000);
    chk("mr_after_imm32", 64'(imm32), 64'h80000000);
    chk("mr_after_type", 64'(type64), 64'h10);
    chk("mr_after_rd", 64'(rd_64), 64'd1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
